input_data_streamer: RTL and testbench

- Parametrised successor to the single-bit input memory reader that feeds the ELM hidden layer.
- Holds NUM_SAMPLES input vectors of NUM_FEATURES words each, DATA_WIDTH bits per word, in an internal loadable memory.
- On a start command, streams one selected sample, or all samples in order, to the hidden-layer datapath over a valid/ready handshake, with feature/sample indices and last flags.

---
 rtl/input_data_streamer.sv | 211 +++++++++++++++++++++
 tb/tb_input_data_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_data_streamer.sv
// input_data_streamer
//   Holds NUM_SAMPLES input vectors of NUM_FEATURES words in a loadable
//   register memory. On a start command it streams one sample, or every
//   sample in order, to the ELM hidden-layer datapath over a valid/ready
//   handshake. Each beat carries feature/sample indices and last flags.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   wr_en, wr_addr, wr_data     memory write port (addr = sample*NF + feature)
//   start, run_all, sample_sel  run command (run_all=1 streams every sample)
//   data_out, data_valid        output beat and its valid flag
//   data_ready                  downstream accept
//   feat_idx, samp_idx          indices of the current beat
//   last_feat, last_samp        beat is the last feature / belongs to last sample
//   busy, done, cmd_err         run in progress, end-of-run pulse, rejected start
module input_data_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_FEATURES = 16,
  parameter int NUM_SAMPLES  = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int FEAT_WIDTH   = 4,
  parameter int SAMP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  run_all,
  input  logic [SAMP_WIDTH-1:0] sample_sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [FEAT_WIDTH-1:0] feat_idx,
  output logic [SAMP_WIDTH-1:0] samp_idx,
  output logic                  last_feat,
  output logic                  last_samp,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int unsigned DEPTH = NUM_FEATURES * NUM_SAMPLES;
  localparam int unsigned NS_U  = NUM_SAMPLES;
  localparam logic [FEAT_WIDTH-1:0] LAST_FEAT = FEAT_WIDTH'(NUM_FEATURES - 1);
  localparam logic [SAMP_WIDTH-1:0] LAST_SAMP = SAMP_WIDTH'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [FEAT_WIDTH-1:0] cur_feat, cur_feat_n;
  logic [SAMP_WIDTH-1:0] cur_samp, cur_samp_n;
  logic [SAMP_WIDTH-1:0] end_samp, end_samp_n;
  // Set once the final beat of the run has been loaded into the output register.
  logic                  issued, issued_n;

  logic [DATA_WIDTH-1:0] data_out_n;
  logic                  data_valid_n;
  logic [FEAT_WIDTH-1:0] feat_idx_n;
  logic [SAMP_WIDTH-1:0] samp_idx_n;
  logic                  last_feat_n;
  logic                  last_samp_n;
  logic                  busy_n;
  logic                  done_n;
  logic                  cmd_err_n;

  // Shared load path: IDLE (first beat) and STREAM both feed these.
  logic                  do_load;
  logic [FEAT_WIDTH-1:0] ld_feat;
  logic [SAMP_WIDTH-1:0] ld_samp;
  logic [SAMP_WIDTH-1:0] ld_end;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  sel_ok;

  assign sel_ok = (32'(sample_sel) < NS_U);

  // Memory is intentionally not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_feat   <= '0;
      cur_samp   <= '0;
      end_samp   <= '0;
      issued     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      feat_idx   <= '0;
      samp_idx   <= '0;
      last_feat  <= 1'b0;
      last_samp  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cur_feat   <= cur_feat_n;
      cur_samp   <= cur_samp_n;
      end_samp   <= end_samp_n;
      issued     <= issued_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      feat_idx   <= feat_idx_n;
      samp_idx   <= samp_idx_n;
      last_feat  <= last_feat_n;
      last_samp  <= last_samp_n;
      busy       <= busy_n;
      done       <= done_n;
      cmd_err    <= cmd_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cur_feat_n   = cur_feat;
    cur_samp_n   = cur_samp;
    end_samp_n   = end_samp;
    issued_n     = issued;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    feat_idx_n   = feat_idx;
    samp_idx_n   = samp_idx;
    last_feat_n  = last_feat;
    last_samp_n  = last_samp;
    busy_n       = busy;
    done_n       = 1'b0;
    cmd_err_n    = 1'b0;
    do_load      = 1'b0;
    ld_feat      = cur_feat;
    ld_samp      = cur_samp;
    ld_end       = end_samp;
    rd_addr      = '0;

    case (state)
      IDLE: begin
        if (start) begin
          if (run_all || sel_ok) begin
            // The first beat is loaded straight from IDLE so data_valid
            // rises on the cycle after start.
            do_load  = 1'b1;
            ld_feat  = '0;
            ld_samp  = run_all ? '0 : sample_sel;
            ld_end   = run_all ? LAST_SAMP : sample_sel;
            issued_n = 1'b0;
            busy_n   = 1'b1;
            state_n  = STREAM;
          end else begin
            cmd_err_n = 1'b1;
          end
        end
      end

      STREAM: begin
        if (data_valid && data_ready) begin
          data_valid_n = 1'b0;
          if (last_feat && last_samp) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = FINISH;
          end
        end
        if ((!data_valid || data_ready) && !issued) begin
          do_load = 1'b1;
        end
      end

      FINISH: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (do_load) begin
      rd_addr      = ADDR_WIDTH'(ld_samp) * ADDR_WIDTH'(NUM_FEATURES) + ADDR_WIDTH'(ld_feat);
      data_out_n   = mem[rd_addr];
      feat_idx_n   = ld_feat;
      samp_idx_n   = ld_samp;
      last_feat_n  = (ld_feat == LAST_FEAT);
      last_samp_n  = (ld_samp == ld_end);
      data_valid_n = 1'b1;
      end_samp_n   = ld_end;
      if (ld_feat == LAST_FEAT) begin
        cur_feat_n = '0;
        cur_samp_n = ld_samp + 1'b1;
        if (ld_samp == ld_end) begin
          issued_n = 1'b1;
        end
      end else begin
        cur_feat_n = ld_feat + 1'b1;
        cur_samp_n = ld_samp;
      end
    end
  end

endmodule

// File: tb/tb_input_data_streamer.sv
// tb_input_data_streamer
//   Scoreboard bench for input_data_streamer. Expected beats are pushed when a
//   run is commanded and popped as the DUT hands beats over.
module tb_input_data_streamer;

  localparam int DW = 8;
  localparam int NF = 16;
  localparam int NS = 16;
  localparam int AW = 8;
  localparam int FW = 4;
  localparam int SW = 5;
  localparam int BW = DW + FW + SW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          run_all;
  logic [SW-1:0] sample_sel;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic [FW-1:0] feat_idx;
  logic [SW-1:0] samp_idx;
  logic          last_feat;
  logic          last_samp;
  logic          busy;
  logic          done;
  logic          cmd_err;

  input_data_streamer #(
    .DATA_WIDTH  (DW),
    .NUM_FEATURES(NF),
    .NUM_SAMPLES (NS),
    .ADDR_WIDTH  (AW),
    .FEAT_WIDTH  (FW),
    .SAMP_WIDTH  (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .run_all   (run_all),
    .sample_sel(sample_sel),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .feat_idx  (feat_idx),
    .samp_idx  (samp_idx),
    .last_feat (last_feat),
    .last_samp (last_samp),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] exp_q [$];
  logic [DW-1:0] model [NF*NS];
  logic [BW-1:0] cur;
  logic [BW-1:0] held;
  bit            stalled = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;

  assign cur = {data_out, feat_idx, samp_idx, last_feat, last_samp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_run(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      for (int f = 0; f < NF; f++) begin
        exp_q.push_back({model[s*NF+f], FW'(f), SW'(s), (f == NF-1), (s == last)});
      end
    end
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (cmd_err) err_cnt++;
      if (stalled) check("hold", 32'({data_valid, cur}), 32'({1'b1, held}));
      stalled = 1'b0;
      if (data_valid) begin
        check("busy_with_valid", 32'(busy), 32'd1);
        if (data_ready) begin
          check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("beat", 32'(cur), 32'(exp_q.pop_front()));
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic all, input logic [SW-1:0] sel);
    start      = 1'b1;
    run_all    = all;
    sample_sel = sel;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxcyc, input bit toggle);
    for (int i = 0; i < maxcyc && done_cnt < target; i++) begin
      tick();
      if (toggle) data_ready = ~data_ready;
    end
    check("done_count", 32'(done_cnt), 32'(target));
    data_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    run_all    = 1'b0;
    sample_sel = '0;
    data_ready = 1'b1;
    #23;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_idx", 32'({feat_idx, samp_idx}), 32'd0);
    check("rst_flags", 32'({last_feat, last_samp, busy, done, cmd_err}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Load mem[i] = i.
    for (int i = 0; i < NF*NS; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = DW'(i);
      model[i] = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Single sample 3, full throughput.
    push_run(3, 3);
    start_cmd(1'b0, 5'd3);
    check("first_valid", 32'(data_valid), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    wait_done(done_cnt + 1, 100, 1'b0);
    check("q_empty_s3", 32'(exp_q.size()), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // All samples with data_ready toggling.
    push_run(0, NS-1);
    start_cmd(1'b1, 5'd0);
    d0 = done_cnt;
    wait_done(d0 + 1, 2000, 1'b1);
    check("q_empty_all", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check("single_done_all", 32'(done_cnt), 32'(d0 + 1));

    // Out-of-range sample select.
    e0 = err_cnt;
    start_cmd(1'b0, 5'd16);
    check("cmd_err_pulse", 32'(cmd_err), 32'd1);
    check("cmd_err_busy", 32'(busy), 32'd0);
    repeat (3) begin
      tick();
      check("cmd_err_no_valid", 32'({data_valid, busy}), 32'd0);
    end
    check("cmd_err_once", 32'(err_cnt), 32'(e0 + 1));

    // Sample 2: start during beat 5, write to 0x28 as beat 8 loads.
    e0 = err_cnt;
    d0 = done_cnt;
    push_run(2, 2);
    start_cmd(1'b0, 5'd2);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      start = (cyc == 5);
      run_all = (cyc == 5);
      wr_en = (cyc == 7);
      wr_addr = 8'h28;
      wr_data = 8'hAA;
    end
    wr_en = 1'b0;
    model[8'h28] = 8'hAA;
    wait_done(d0 + 1, 100, 1'b0);
    check("q_empty_s2", 32'(exp_q.size()), 32'd0);
    check("mid_start_no_err", 32'(err_cnt), 32'(e0));
    push_run(2, 2);
    start_cmd(1'b0, 5'd2);
    wait_done(d0 + 2, 100, 1'b0);
    check("q_empty_s2_rerun", 32'(exp_q.size()), 32'd0);

    // Reset at beat 7 of a sample-5 run.
    d0 = done_cnt;
    push_run(5, 5);
    start_cmd(1'b0, 5'd5);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_data", 32'({data_out, feat_idx, samp_idx}), 32'd0);
    check("arst_flags", 32'({last_feat, last_samp, busy, done, cmd_err}), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("arst_no_done", 32'(done_cnt), 32'(d0));
    push_run(5, 5);
    start_cmd(1'b0, 5'd5);
    wait_done(d0 + 1, 100, 1'b0);
    check("q_empty_s5", 32'(exp_q.size()), 32'd0);

    // Back-to-back start in FINISH and in the following cycle.
    d0 = done_cnt;
    push_run(1, 1);
    start_cmd(1'b0, 5'd1);
    for (int i = 0; i < 100 && !done; i++) tick();
    check("finish_seen", 32'(done), 32'd1);
    start      = 1'b1;
    run_all    = 1'b0;
    sample_sel = 5'd4;
    tick();
    check("finish_start_ignored", 32'({busy, data_valid}), 32'd0);
    push_run(4, 4);
    tick();
    start = 1'b0;
    check("b2b_valid", 32'(data_valid), 32'd1);
    check("b2b_samp", 32'(samp_idx), 32'd4);
    wait_done(d0 + 2, 100, 1'b0);
    check("q_empty_b2b", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
